// File: rtl/instruction_decoder_if.sv
// Decoder bus: the fetched instruction going in, and the decoded
// register-file / ALU controls coming out.
interface instruction_decoder_if;
  logic [7:0] instruction;
  logic [2:0] read_reg1;
  logic [2:0] read_reg2;
  logic [2:0] write_reg;
  logic [7:0] write_data;
  logic [3:0] operation;
  logic       write_enable;
  logic       reg_write;

  // Fetch side: drives the instruction and observes the decode.
  modport master (
    output instruction,
    input  read_reg1, read_reg2, write_reg, write_data,
    input  operation, write_enable, reg_write
  );

  // Decoder side: consumes the instruction and produces the controls.
  modport slave (
    input  instruction,
    output read_reg1, read_reg2, write_reg, write_data,
    output operation, write_enable, reg_write
  );
endinterface

// File: rtl/instruction_decoder.sv
// Registered instruction decoder for the 8-bit CPU.
// Instruction layout: [7:4] opcode, [3:2] field A, [1:0] field B.
// Every output comes from a flop, so decode latency is one cycle and
// there is no combinational path from instruction to outputs.
module instruction_decoder (
  input  logic                  clk,
  input  logic                  rst,
  instruction_decoder_if.slave  bus
);

  typedef struct packed {
    logic [2:0] rr1;
    logic [2:0] rr2;
    logic [2:0] wr;
    logic [7:0] wd;
    logic [3:0] op;
    logic       we;
    logic       rw;
  } dec_t;

  dec_t       dec_d, dec_q;
  logic [3:0] opcode;
  logic [2:0] fld_a, fld_b;

  assign opcode = bus.instruction[7:4];
  assign fld_a  = {1'b0, bus.instruction[3:2]};
  assign fld_b  = {1'b0, bus.instruction[1:0]};

  // Decode the opcode; the all-zero default covers NOP and reserved opcodes.
  always_comb begin
    dec_d = '0;
    case (opcode)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        // two-operand ALU ops, destination is the first source
        dec_d.rr1 = fld_a;
        dec_d.rr2 = fld_b;
        dec_d.wr  = fld_a;
        dec_d.we  = 1'b1;
        dec_d.rw  = 1'b1;
        case (opcode)
          4'h1:    dec_d.op = 4'b0000;
          4'h2:    dec_d.op = 4'b0001;
          4'h3:    dec_d.op = 4'b0010;
          4'h4:    dec_d.op = 4'b0011;
          default: dec_d.op = 4'b0100;
        endcase
      end
      4'h6, 4'h7, 4'h8: begin
        // single-operand ALU ops leave port 2 idle
        dec_d.rr1 = fld_a;
        dec_d.wr  = fld_a;
        dec_d.we  = 1'b1;
        dec_d.rw  = 1'b1;
        case (opcode)
          4'h6:    dec_d.op = 4'b0101;
          4'h7:    dec_d.op = 4'b0110;
          default: dec_d.op = 4'b0111;
        endcase
      end
      4'h9: begin
        // MOV A <- B: source comes from field B through ALU pass-A
        dec_d.rr1 = fld_b;
        dec_d.wr  = fld_a;
        dec_d.op  = 4'b1000;
        dec_d.we  = 1'b1;
        dec_d.rw  = 1'b1;
      end
      4'hA: begin
        // LDI: 2-bit immediate written back directly, ALU result unused
        dec_d.wr  = fld_a;
        dec_d.wd  = {6'b0, bus.instruction[1:0]};
        dec_d.op  = 4'b1111;
        dec_d.we  = 1'b1;
        dec_d.rw  = 1'b0;
      end
      default: dec_d = '0;
    endcase
  end

  // Output register; reset wins over decode.
  always_ff @(posedge clk) begin
    if (rst) dec_q <= '0;
    else     dec_q <= dec_d;
  end

  assign bus.read_reg1    = dec_q.rr1;
  assign bus.read_reg2    = dec_q.rr2;
  assign bus.write_reg    = dec_q.wr;
  assign bus.write_data   = dec_q.wd;
  assign bus.operation    = dec_q.op;
  assign bus.write_enable = dec_q.we;
  assign bus.reg_write    = dec_q.rw;

endmodule

// File: tb/tb_instruction_decoder.sv
// Bench for instruction_decoder: directed vector table, hand-written
// latency / reset-priority sequence, then random instructions against a
// reference model built from the opcode rules.
module tb_instruction_decoder;

  logic clk = 1'b0;
  logic rst;
  instruction_decoder_if bus ();

  instruction_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] instr;
    logic [2:0] rr1;
    logic [2:0] rr2;
    logic [2:0] wr;
    logic [7:0] wd;
    logic [3:0] op;
    logic       we;
    logic       rw;
  } vec_t;

  function automatic logic [22:0] pack(input logic [2:0] rr1, rr2, wr,
                                       input logic [7:0] wd, input logic [3:0] op,
                                       input logic we, rw);
    return {rr1, rr2, wr, wd, op, we, rw};
  endfunction

  function automatic logic [22:0] outs();
    return pack(bus.read_reg1, bus.read_reg2, bus.write_reg, bus.write_data,
                bus.operation, bus.write_enable, bus.reg_write);
  endfunction

  // Reference: opcodes 1..8 are ALU ops numbered opcode-1, 1..5 read both
  // fields, 6..8 read only field A; 9 is MOV, 10 is LDI, rest do nothing.
  function automatic logic [22:0] model(input logic r, input logic [7:0] ins);
    int         opc = int'(ins[7:4]);
    logic [2:0] a   = {1'b0, ins[3:2]};
    logic [2:0] b   = {1'b0, ins[1:0]};
    logic [3:0] alu_op;
    if (r) return '0;
    alu_op = 4'(opc - 1);
    if (opc >= 1 && opc <= 5) return pack(a, b, a, 8'd0, alu_op, 1'b1, 1'b1);
    if (opc >= 6 && opc <= 8) return pack(a, 3'd0, a, 8'd0, alu_op, 1'b1, 1'b1);
    if (opc == 9)             return pack(b, 3'd0, a, 8'd0, 4'd8, 1'b1, 1'b1);
    if (opc == 10)            return pack(3'd0, 3'd0, a, {6'd0, ins[1:0]}, 4'd15, 1'b1, 1'b0);
    return '0;
  endfunction

  task automatic chk(input string nm, input logic [22:0] act, input logic [22:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (rr1,rr2,wr,wd,op,we,rw packed)", nm, act, exp);
    end
  endtask

  // Drive at the falling edge, sample just after the next rising edge.
  task automatic apply(input logic r, input logic [7:0] ins);
    @(negedge clk);
    rst = r;
    bus.instruction = ins;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    logic [22:0] hold;
    rst = 1'b1;
    bus.instruction = 8'h00;

    vecs.push_back('{"rst0",    1, 8'h1F, 0, 0, 0, 8'h00, 4'h0, 0, 0});
    vecs.push_back('{"rst1",    1, 8'h1F, 0, 0, 0, 8'h00, 4'h0, 0, 0});
    vecs.push_back('{"add_rel", 0, 8'h1F, 3, 3, 3, 8'h00, 4'h0, 1, 1});
    vecs.push_back('{"add_r0",  0, 8'h10, 0, 0, 0, 8'h00, 4'h0, 1, 1});
    vecs.push_back('{"sub",     0, 8'h21, 0, 1, 0, 8'h00, 4'h1, 1, 1});
    vecs.push_back('{"and",     0, 8'h3E, 3, 2, 3, 8'h00, 4'h2, 1, 1});
    vecs.push_back('{"or",      0, 8'h4E, 3, 2, 3, 8'h00, 4'h3, 1, 1});
    vecs.push_back('{"xor",     0, 8'h5E, 3, 2, 3, 8'h00, 4'h4, 1, 1});
    vecs.push_back('{"not",     0, 8'h6E, 3, 0, 3, 8'h00, 4'h5, 1, 1});
    vecs.push_back('{"shl",     0, 8'h7E, 3, 0, 3, 8'h00, 4'h6, 1, 1});
    vecs.push_back('{"shr",     0, 8'h8E, 3, 0, 3, 8'h00, 4'h7, 1, 1});
    vecs.push_back('{"mov",     0, 8'h96, 2, 0, 1, 8'h00, 4'h8, 1, 1});
    vecs.push_back('{"ldi",     0, 8'hAB, 0, 0, 2, 8'h03, 4'hF, 1, 0});
    vecs.push_back('{"nop",     0, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 0});
    vecs.push_back('{"ldi_max", 0, 8'hAF, 0, 0, 3, 8'h03, 4'hF, 1, 0});
    vecs.push_back('{"rsv_b",   0, 8'hBF, 0, 0, 0, 8'h00, 4'h0, 0, 0});
    vecs.push_back('{"rsv_c",   0, 8'hC5, 0, 0, 0, 8'h00, 4'h0, 0, 0});
    vecs.push_back('{"rsv_d",   0, 8'hDA, 0, 0, 0, 8'h00, 4'h0, 0, 0});
    vecs.push_back('{"rsv_e",   0, 8'hEF, 0, 0, 0, 8'h00, 4'h0, 0, 0});
    vecs.push_back('{"rsv_f",   0, 8'hF3, 0, 0, 0, 8'h00, 4'h0, 0, 0});
    vecs.push_back('{"xor_b",   0, 8'h5B, 2, 3, 2, 8'h00, 4'h4, 1, 1});
    vecs.push_back('{"rst_add", 1, 8'h1F, 0, 0, 0, 8'h00, 4'h0, 0, 0});

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].instr);
      chk(vecs[i].name, outs(),
          pack(vecs[i].rr1, vecs[i].rr2, vecs[i].wr, vecs[i].wd,
               vecs[i].op, vecs[i].we, vecs[i].rw));
    end

    // Hold: same instruction for a second edge keeps the outputs.
    apply(1'b0, 8'h96);
    hold = outs();
    chk("mov_first", hold, pack(3'd2, 3'd0, 3'd1, 8'd0, 4'd8, 1'b1, 1'b1));
    @(posedge clk); #1;
    chk("mov_hold", outs(), pack(3'd2, 3'd0, 3'd1, 8'd0, 4'd8, 1'b1, 1'b1));

    // Mid-cycle change: nothing moves until the next rising edge.
    #2 bus.instruction = 8'h21;
    #1 chk("mid_nochg", outs(), pack(3'd2, 3'd0, 3'd1, 8'd0, 4'd8, 1'b1, 1'b1));
    @(negedge clk);
    chk("mid_neg", outs(), pack(3'd2, 3'd0, 3'd1, 8'd0, 4'd8, 1'b1, 1'b1));
    @(posedge clk); #1;
    chk("mid_take", outs(), pack(3'd0, 3'd1, 3'd0, 8'd0, 4'd1, 1'b1, 1'b1));

    // Reset raised alongside a valid ADD mid-stream, then released.
    apply(1'b1, 8'h1F);
    chk("rst_prio", outs(), '0);
    apply(1'b0, 8'h1F);
    chk("rst_rel2", outs(), pack(3'd3, 3'd3, 3'd3, 8'd0, 4'd0, 1'b1, 1'b1));

    // Random instructions with occasional reset against the model.
    for (int k = 0; k < 300; k++) begin
      logic       r;
      logic [7:0] ins;
      r   = ($urandom_range(0, 9) == 0);
      ins = 8'($urandom);
      apply(r, ins);
      chk($sformatf("rand%0d_%h_%0d", k, ins, r), outs(), model(r, ins));
    end

    // Exhaustive sweep of every instruction word.
    for (int k = 0; k < 256; k++) begin
      apply(1'b0, 8'(k));
      chk($sformatf("sweep_%h", k[7:0]), outs(), model(1'b0, 8'(k)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_decoder.md
Name: instruction_decoder

Overview:
- Registered decoder for the 8-bit CPU.
- Splits each 8-bit instruction into a 4-bit opcode and register/immediate fields.
- Drives register-file read/write addresses, write-back immediate data, the ALU operation code, and write strobes.
- Sits between instruction fetch and the register file / ALU.

Parameters:
- None. Widths are fixed: 8-bit instruction, 3-bit register index, 8-bit data, 4-bit ALU op.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- instruction  input  8  instruction word: [7:4] opcode, [3:2] field A, [1:0] field B
- read_reg1  output  3  register-file read port 1 address
- read_reg2  output  3  register-file read port 2 address
- write_reg  output  3  register-file destination address
- write_data  output  8  immediate write-back data (LDI only, else 0)
- operation  output  4  ALU operation code
- write_enable  output  1  register-file write strobe
- reg_write  output  1  write-back source select: 1 = ALU result, 0 = write_data immediate

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- All outputs are registered, sampled at the rising edge of clk. Latency is exactly 1 cycle from instruction to outputs.
- rst=1 at an edge forces all outputs to 0, including mid-stream. rst has priority over decode. The first decode happens at the first edge with rst=0.
- Field mapping, unless overridden per opcode below:
  - read_reg1 = {0, instr[3:2]}
  - read_reg2 = {0, instr[1:0]}
  - write_reg = {0, instr[3:2]} (two-address form: destination = first source)
  - Register index bit 2 is always 0.
- Opcode table: opcode -> operation, write_enable, reg_write:
  - 0000 NOP: op 0000, we 0, rw 0; all address outputs 0
  - 0001 ADD: op 0000, we 1, rw 1
  - 0010 SUB: op 0001, we 1, rw 1
  - 0011 AND: op 0010, we 1, rw 1
  - 0100 OR: op 0011, we 1, rw 1
  - 0101 XOR: op 0100, we 1, rw 1
  - 0110 NOT: op 0101, we 1, rw 1; read_reg2 = 0
  - 0111 SHL: op 0110, we 1, rw 1; read_reg2 = 0
  - 1000 SHR: op 0111, we 1, rw 1; read_reg2 = 0
  - 1001 MOV: op 1000 (pass A), we 1, rw 1; read_reg1 = {0, instr[1:0]}, read_reg2 = 0, write_reg = {0, instr[3:2]}
  - 1010 LDI: op 1111, we 1, rw 0; write_data = {6'b0, instr[1:0]}; read_reg1 and read_reg2 = 0; write_reg = {0, instr[3:2]}
  - 1011-1111: reserved; decoded exactly as NOP
- write_data is 0 for every opcode except LDI.
- Outputs hold their value while the instruction is unchanged. A new instruction takes effect only at the next rising edge.
- Purely synchronous: no combinational path from instruction to any output.

Test Plan:
- Reset: rst=1 for 2 cycles with instr=8'h1F -> every output 0. Release rst -> next edge decodes ADD: read_reg1=011, read_reg2=011, write_reg=011, op 0000, we 1, rw 1.
- ADD/SUB: instr=00010000 -> read_reg1=000, read_reg2=000, write_reg=000, write_data=0, op=0000, we=1, rw=1. Next instr=00100001 -> read_reg1=000, read_reg2=001, write_reg=000, op=0001, we=1, rw=1.
- Full ALU sweep: opcodes 0011-1000 with operand bits 1110 -> op 0010..0111, read_reg1=011, write_reg=011; read_reg2=010 for AND/OR/XOR and 000 for NOT/SHL/SHR.
- MOV/LDI: instr=10010110 -> read_reg1=010, write_reg=001, op=1000, rw=1. Then instr=10101011 -> write_reg=010, write_data=00000011, op=1111, we=1, rw=0.
- NOP/reserved: instr=00000000 and each of 1011xxxx-1111xxxx -> we=0, rw=0, op=0000, all addresses and write_data 0.
- Latency and reset priority: change instr mid-cycle -> outputs change only at the next rising edge. Assert rst together with a valid ADD -> outputs 0 at that edge.
